// File: rtl/axs_rd_fsm.sv
// AXI read responder for the accelerator output path: serves read bursts by popping
// the varint / raw output FIFOs, or by returning a status word, one beat per two cycles.
module axs_rd_fsm #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   axs_s0_arid,
  input  logic [31:0]       axs_s0_araddr,
  input  logic [7:0]        axs_s0_arlen,
  input  logic [2:0]        axs_s0_arsize,
  input  logic [1:0]        axs_s0_arburst,
  input  logic              axs_s0_arvalid,
  output logic              axs_s0_arready,
  output logic [ID_W-1:0]   axs_s0_rid,
  output logic [DATA_W-1:0] axs_s0_rdata,
  output logic [1:0]        axs_s0_rresp,
  output logic              axs_s0_rlast,
  output logic              axs_s0_rvalid,
  input  logic              axs_s0_rready,
  input  logic              varint_out_fifo_empty,
  input  logic [DATA_W-1:0] varint_out_fifo_data,
  output logic              varint_out_fifo_pop,
  input  logic              raw_data_out_fifo_empty,
  input  logic [DATA_W-1:0] raw_data_out_fifo_data,
  output logic              raw_data_out_fifo_pop
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] TGT_VARINT = 2'b00;
  localparam logic [1:0] TGT_RAW    = 2'b01;
  localparam logic [1:0] TGT_STATUS = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t          state;
  logic [ID_W-1:0] rid_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_cnt;
  logic [1:0]      tgt_q;
  logic            size_err_q;

  logic unused_addr;
  assign unused_addr = ^{axs_s0_arburst, axs_s0_araddr[31:13], axs_s0_araddr[10:0]};

  // {rresp, rdata} for one beat; an empty FIFO answers SLVERR instead of stalling
  function automatic logic [DATA_W+1:0] beat_word(
    input logic [1:0]        tgt,
    input logic              size_err,
    input logic              v_empty,
    input logic [DATA_W-1:0] v_data,
    input logic              r_empty,
    input logic [DATA_W-1:0] r_data
  );
    logic [DATA_W+1:0] w;
    w = {RESP_SLVERR, {DATA_W{1'b0}}};
    if (!size_err) begin
      case (tgt)
        TGT_VARINT: if (!v_empty) w = {RESP_OKAY, v_data};
        TGT_RAW:    if (!r_empty) w = {RESP_OKAY, r_data};
        TGT_STATUS: w = {RESP_OKAY, {(DATA_W-2){1'b0}}, r_empty, v_empty};
        default:    w = {RESP_SLVERR, {DATA_W{1'b0}}};
      endcase
    end
    return w;
  endfunction

  // Pops are decoded from the LOAD state so the FIFO advances on the same edge that captures rdata
  assign varint_out_fifo_pop = (state == LOAD) && (tgt_q == TGT_VARINT) && !size_err_q
                               && !varint_out_fifo_empty;
  assign raw_data_out_fifo_pop = (state == LOAD) && (tgt_q == TGT_RAW) && !size_err_q
                                 && !raw_data_out_fifo_empty;

  assign axs_s0_rid = rid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      axs_s0_arready <= 1'b0;
      axs_s0_rvalid  <= 1'b0;
      axs_s0_rlast   <= 1'b0;
      axs_s0_rdata   <= '0;
      axs_s0_rresp   <= RESP_OKAY;
      rid_q          <= '0;
      len_q          <= '0;
      beat_cnt       <= '0;
      tgt_q          <= TGT_VARINT;
      size_err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (axs_s0_arvalid && axs_s0_arready) begin
            rid_q          <= axs_s0_arid;
            len_q          <= axs_s0_arlen;
            tgt_q          <= axs_s0_araddr[12:11];
            size_err_q     <= (axs_s0_arsize != 3'b010);
            beat_cnt       <= '0;
            axs_s0_arready <= 1'b0;
            state          <= LOAD;
          end else begin
            axs_s0_arready <= 1'b1;
          end
        end
        LOAD: begin
          {axs_s0_rresp, axs_s0_rdata} <= beat_word(tgt_q, size_err_q,
                                                    varint_out_fifo_empty, varint_out_fifo_data,
                                                    raw_data_out_fifo_empty, raw_data_out_fifo_data);
          axs_s0_rlast  <= (beat_cnt == len_q);
          axs_s0_rvalid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (axs_s0_rready) begin
            axs_s0_rvalid <= 1'b0;
            axs_s0_rlast  <= 1'b0;
            if (axs_s0_rlast) begin
              axs_s0_arready <= 1'b1;
              state          <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axs_rd_fsm.md
# axs_rd_fsm

AXI read-side responder for the accelerator's output path. It accepts AXI read bursts from the host and pops results from the two output FIFOs, `varint_out` (decoded values) and `raw_data_out` (pass-through bytes). It returns each popped word as an R-channel beat. It is the read-direction counterpart to the write FSM that fills the accelerator's input FIFOs, and it sits between the AXI interconnect slave port and the output FIFOs.

## Interface
- ID_W, 4, width of arid/rid
- DATA_W, 32, AXI data width and FIFO word width (only 32 supported)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  reset, asynchronous, active-low
- axs_s0_arid  input  ID_W  read ID, captured on AR handshake
- axs_s0_araddr  input  32  read address; bits [12:11] select the target
- axs_s0_arlen  input  8  beats minus one
- axs_s0_arsize  input  3  beat size; only 3'b010 is legal
- axs_s0_arburst  input  2  ignored; all beats address the same target
- axs_s0_arvalid  input  1  AR valid
- axs_s0_arready  output  1  AR ready
- axs_s0_rid  output  ID_W  returned ID
- axs_s0_rdata  output  DATA_W  read data
- axs_s0_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR
- axs_s0_rlast  output  1  final beat of the burst
- axs_s0_rvalid  output  1  R valid
- axs_s0_rready  input  1  R ready
- varint_out_fifo_empty  input  1  varint FIFO empty
- varint_out_fifo_data  input  DATA_W  varint FIFO head word (show-ahead)
- varint_out_fifo_pop  output  1  one-cycle pop strobe
- raw_data_out_fifo_empty  input  1  raw FIFO empty
- raw_data_out_fifo_data  input  DATA_W  raw FIFO head word (show-ahead)
- raw_data_out_fifo_pop  output  1  one-cycle pop strobe

## Operation
- **Target decode** (from araddr[12:11], latched at AR handshake):
  - 00: varint FIFO.
  - 01: raw FIFO.
  - 10: status word {30'b0, raw_data_out_fifo_empty, varint_out_fifo_empty}. Never pops.
  - 11: unmapped. Every beat returns 0 with SLVERR.
- **Latched burst context:** rid, arlen, target, and size_err (arsize != 3'b010). All are held for the whole burst.
- **States:**
  - IDLE: arready=1, rvalid=0. On arvalid, latch context, clear beat_cnt to 0, go to LOAD.
  - LOAD: arready=0. Sample the target for this beat and register rdata/rresp; go to SEND.
  - SEND: rvalid=1. Hold rdata, rresp, rlast and rid stable until rready. On rready: if rlast, go to IDLE; otherwise increment beat_cnt and go to LOAD.
- **Beat sampling in LOAD:**
  - FIFO target, size_err=0, FIFO not empty: rdata = head word, rresp = OKAY, the matching pop is high this cycle only.
  - FIFO target, FIFO empty: rdata = 0, rresp = SLVERR, no pop. The responder never stalls waiting for data.
  - size_err=1: rdata = 0, rresp = SLVERR, no pop, regardless of target.
  - Status target: rdata = live flags sampled in LOAD, rresp = OKAY unless size_err.
- **Burst length and rlast:**
  - rlast = (beat_cnt == latched arlen).
  - beat_cnt is 8 bits; arlen=255 yields exactly 256 beats with no wrap before rlast.
  - Every burst returns exactly arlen+1 beats, including error bursts.
- **Pop rules:**
  - At most one pop per beat; never both pops in the same cycle.
  - Pops occur only in LOAD.
- **Reset:**
  - Asynchronous assertion forces IDLE and all outputs to reset values.
  - A burst in flight is abandoned; no further pops occur.
  - FIFO contents are not touched.
- Only one outstanding read at a time.

## Timing
- **Reset values:**
  - arready = 0 while reset is low, 1 in IDLE after release.
  - rvalid = 0, rlast = 0, rdata = 0, rresp = 2'b00, rid = 0.
  - Both pops = 0.
- **First beat latency:** AR handshake at edge N → LOAD in cycle N+1 (pop in that cycle) → rvalid high from edge N+2.
- **Subsequent beats:** one beat every 2 cycles when rready is held high. The rready handshake at edge M gives LOAD in M+1 and the next rvalid at M+2.
- **Back-to-back bursts:** arready returns to 1 the cycle after the final rready handshake.
- **Pop-to-data ordering:** pop and the registered rdata capture happen on the same edge; the FIFO advances after the capture.
- **FIFO going empty:** a FIFO that becomes empty mid-burst affects only beats whose LOAD falls after the empty flag rises.
- **rready low:** holds SEND indefinitely with no extra pops.

## Test plan
- **Single-beat read:** varint FIFO holds 0xDEADBEEF; AR addr 0x000, len 0, size 2, id 5 → one beat: rdata 0xDEADBEEF, rresp 00, rlast 1, rid 5; exactly one varint pop; first rvalid 2 cycles after AR handshake.
- **Four-beat raw burst:** raw FIFO holds 1,2,3,4; AR addr 0x800, len 3; rready toggled 1/0 → data 1,2,3,4 in order, rlast only on beat 4, 4 raw pops, 0 varint pops, data stable while rready is low.
- **Underflow:** varint FIFO holds 2 words; AR len 3 → beats 1–2 OKAY with data, beats 3–4 return 0 with SLVERR, exactly 2 pops, rlast on beat 4.
- **Status and errors:**
  - Status read with varint empty and raw non-empty → rdata 0x00000001, no pops.
  - Addr 0x1800 → SLVERR.
  - arsize 3'b001 on the varint target → SLVERR for all beats, no pops.
- **Max length and reset:**
  - arlen 255 with the FIFO kept full → 256 beats, rlast on beat 256 only.
  - Reset asserted at beat 10 of that burst → rvalid 0 and arready 0 immediately; after release, IDLE with arready 1 and no further pops.
